// File: rtl/fixed_vec_streamer.sv
// fixed_vec_streamer: buffers two operand vectors, streams them to the MAC
// and captures the single result beat. Watchdog enabled by VEC_TIMEOUT_EN.
module fixed_vec_streamer #(
  parameter int WI1     = 4,
  parameter int WF1     = 8,
  parameter int WI2     = 3,
  parameter int WF2     = 5,
  parameter int WIO     = 15,
  parameter int WFO     = 30,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WI1+WF1-1:0]   wr_a,
  input  logic [WI2+WF2-1:0]   wr_b,
  input  logic                 start,
  input  logic [AW:0]          len,
  output logic                 busy,
  output logic                 done,
  output logic [WI1+WF1-1:0]   A_data,
  output logic                 A_valid,
  input  logic                 A_ready,
  output logic                 A_last,
  output logic [WI2+WF2-1:0]   B_data,
  output logic                 B_valid,
  input  logic                 B_ready,
  output logic                 B_last,
  input  logic [WIO+WFO-1:0]   out_data,
  input  logic                 out_valid,
  output logic                 out_ready,
  input  logic                 out_last,
  input  logic                 overflow,
  input  logic                 underflow,
  output logic [WIO+WFO-1:0]   result,
  output logic                 result_ovf,
  output logic                 result_unf,
  output logic                 timeout
);

  localparam int WA = WI1 + WF1;
  localparam int WB = WI2 + WF2;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RES,
    DONE
  } state_t;

  state_t        state;
  logic [WA-1:0] buf_a [DEPTH];
  logic [WB-1:0] buf_b [DEPTH];
  logic [AW-1:0] a_ptr;
  logic [AW-1:0] b_ptr;
  logic [AW-1:0] a_nxt;
  logic [AW-1:0] b_nxt;
  logic [AW-1:0] lm1;
  logic          a_fin;
  logic          b_fin;
  logic          a_fire;
  logic          b_fire;
  logic          a_end;
  logic          b_end;
  logic          len_ok;
  logic          res_fire;
  logic          unused_in;

  assign a_fire   = A_valid && A_ready;
  assign b_fire   = B_valid && B_ready;
  assign a_end    = a_fin || (a_fire && A_last);
  assign b_end    = b_fin || (b_fire && B_last);
  assign a_nxt    = a_ptr + AW'(1);
  assign b_nxt    = b_ptr + AW'(1);
  assign len_ok   = (len != '0) &&
                    (len <= (AW+1)'(DEPTH));
  assign res_fire = out_valid && out_ready;

  // result end marker carries no information for a single-beat result
  assign unused_in = out_last ^ (TIMEOUT == 0);

`ifdef VEC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
`else
  assign timeout = 1'b0;
`endif

  // operand buffer; loadable only while idle, kept across reset
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) begin
      buf_a[wr_addr] <= wr_a;
      buf_b[wr_addr] <= wr_b;
    end
  end

  // job FSM with registered stream, handshake and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      A_data     <= '0;
      A_valid    <= 1'b0;
      A_last     <= 1'b0;
      B_data     <= '0;
      B_valid    <= 1'b0;
      B_last     <= 1'b0;
      out_ready  <= 1'b0;
      result     <= '0;
      result_ovf <= 1'b0;
      result_unf <= 1'b0;
      a_ptr      <= '0;
      b_ptr      <= '0;
      lm1        <= '0;
      a_fin      <= 1'b0;
      b_fin      <= 1'b0;
`ifdef VEC_TIMEOUT_EN
      timeout    <= 1'b0;
      to_cnt     <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && len_ok) begin
            state   <= SEND;
            busy    <= 1'b1;
            a_ptr   <= '0;
            b_ptr   <= '0;
            lm1     <= len[AW-1:0] - AW'(1);
            a_fin   <= 1'b0;
            b_fin   <= 1'b0;
            A_valid <= 1'b1;
            B_valid <= 1'b1;
            A_data  <= buf_a[0];
            B_data  <= buf_b[0];
            A_last  <= (len == (AW+1)'(1));
            B_last  <= (len == (AW+1)'(1));
`ifdef VEC_TIMEOUT_EN
            timeout <= 1'b0;
`endif
          end
        end
        SEND: begin
          if (a_fire) begin
            if (A_last) begin
              A_valid <= 1'b0;
              A_last  <= 1'b0;
              a_fin   <= 1'b1;
            end else begin
              a_ptr  <= a_nxt;
              A_data <= buf_a[a_nxt];
              A_last <= (a_nxt == lm1);
            end
          end
          if (b_fire) begin
            if (B_last) begin
              B_valid <= 1'b0;
              B_last  <= 1'b0;
              b_fin   <= 1'b1;
            end else begin
              b_ptr  <= b_nxt;
              B_data <= buf_b[b_nxt];
              B_last <= (b_nxt == lm1);
            end
          end
          if (a_end && b_end) begin
            state     <= WAIT_RES;
            out_ready <= 1'b1;
`ifdef VEC_TIMEOUT_EN
            to_cnt    <= '0;
`endif
          end
        end
        WAIT_RES: begin
          if (res_fire) begin
            result     <= out_data;
            result_ovf <= overflow;
            result_unf <= underflow;
            out_ready  <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
`ifdef VEC_TIMEOUT_EN
          else if (to_cnt == TW'(TIMEOUT - 1)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_ready <= 1'b0;
            timeout   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_vec_streamer.sv
// tb_fixed_vec_streamer: directed checks of the vector streamer
// Define VEC_TIMEOUT_EN on both files to exercise the watchdog.
module tb_fixed_vec_streamer;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [11:0] wr_a;
  logic [7:0]  wr_b;
  logic        start;
  logic [4:0]  len;
  logic        busy;
  logic        done;
  logic [11:0] A_data;
  logic        A_valid;
  logic        A_ready;
  logic        A_last;
  logic [7:0]  B_data;
  logic        B_valid;
  logic        B_ready;
  logic        B_last;
  logic [44:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        overflow;
  logic        underflow;
  logic [44:0] result;
  logic        result_ovf;
  logic        result_unf;
  logic        timeout;

  int n_cmp;
  int n_bad;

  logic [11:0] exp_a [4];
  logic [7:0]  exp_b [4];

  fixed_vec_streamer #(
    .DEPTH   (16),
    .TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_a       (wr_a),
    .wr_b       (wr_b),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .A_data     (A_data),
    .A_valid    (A_valid),
    .A_ready    (A_ready),
    .A_last     (A_last),
    .B_data     (B_data),
    .B_valid    (B_valid),
    .B_ready    (B_ready),
    .B_last     (B_last),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .overflow   (overflow),
    .underflow  (underflow),
    .result     (result),
    .result_ovf (result_ovf),
    .result_unf (result_unf),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [4:0] l);
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // walks a running job from t+1 until WAIT_RES, checking every beat
  task automatic run_stream(input int n, input bit a_tog,
                            input bit b_stl, input bit poke,
                            output int cyc);
    int ac;
    int bc;
    int st;
    bit fa;
    bit fb;
    ac  = 0;
    bc  = 0;
    st  = 0;
    cyc = 0;
    while (!(ac == n && bc == n) && cyc < 100) begin
      A_ready = a_tog ? (cyc % 2 == 0) : 1'b1;
      if (b_stl && bc == 2 && st < 3) begin
        B_ready = 1'b0;
        st++;
      end else begin
        B_ready = 1'b1;
      end
      start   = poke && cyc == 1;
      wr_en   = poke && cyc == 1;
      len     = 5'd2;
      wr_addr = 4'd2;
      wr_a    = 12'hABC;
      wr_b    = 8'h5A;
      chk("a_valid", A_valid, ac < n);
      chk("b_valid", B_valid, bc < n);
      if (ac < n) begin
        chk("a_data", A_data, exp_a[ac]);
        chk("a_last", A_last, ac == n - 1);
      end
      if (bc < n) begin
        chk("b_data", B_data, exp_b[bc]);
        chk("b_last", B_last, bc == n - 1);
      end
      chk("busy_send", busy, 1);
      chk("ready_send", out_ready, 0);
      fa = A_valid && A_ready;
      fb = B_valid && B_ready;
      tick();
      cyc++;
      if (fa) ac++;
      if (fb) bc++;
    end
    start = 1'b0;
    wr_en = 1'b0;
    chk("stream_end", ac == n && bc == n, 1);
    chk("wait_ready", out_ready, 1);
    chk("wait_a_valid", A_valid, 0);
    chk("wait_b_valid", B_valid, 0);
    chk("wait_done", done, 0);
  endtask

  task automatic finish_job(input logic [44:0] d,
                            input logic o, input logic u);
    out_valid = 1'b1;
    out_data  = d;
    overflow  = o;
    underflow = u;
    tick();
    out_valid = 1'b0;
    chk("done_pulse", done, 1);
    chk("result", result, d);
    chk("result_ovf", result_ovf, o);
    chk("result_unf", result_unf, u);
    chk("ready_drop", out_ready, 0);
    tick();
    chk("done_clear", done, 0);
    chk("busy_clear", busy, 0);
    chk("result_hold", result, d);
  endtask

  task automatic bad_len(input logic [4:0] l);
    launch(l);
    chk("badlen_a_valid", A_valid, 0);
    chk("badlen_b_valid", B_valid, 0);
    chk("badlen_busy", busy, 0);
    tick();
    chk("badlen_done", done, 0);
    chk("badlen_busy2", busy, 0);
  endtask

  initial begin
    int cyc;
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_a      = '0;
    wr_b      = '0;
    start     = 1'b0;
    len       = '0;
    A_ready   = 1'b1;
    B_ready   = 1'b1;
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    // A in Q4.8: 1.0, 2.0, -0.5, 0.25
    exp_a[0] = 12'h100;
    exp_a[1] = 12'h200;
    exp_a[2] = 12'hF80;
    exp_a[3] = 12'h040;
    // B in Q3.5: 1.0, 0.5, 2.0, then 8'h80 (4.0 wraps in Q3.5;
    // the raw pattern must still pass through unchanged)
    exp_b[0] = 8'h20;
    exp_b[1] = 8'h10;
    exp_b[2] = 8'h40;
    exp_b[3] = 8'h80;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_a_valid", A_valid, 0);
    chk("rst_b_valid", B_valid, 0);
    chk("rst_a_last", A_last, 0);
    chk("rst_b_last", B_last, 0);
    chk("rst_out_ready", out_ready, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_a_data", A_data, 0);
    chk("rst_b_data", B_data, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {result_ovf, result_unf}, 0);

    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(i);
      wr_a    = exp_a[i];
      wr_b    = exp_b[i];
      tick();
    end
    wr_en = 1'b0;

    // plain job, both readies high
    launch(5'd4);
    run_stream(4, 0, 0, 0, cyc);
    chk("wait_cycle", cyc, 4);
    finish_job(45'h0_8000_0000, 1'b0, 1'b0);

    // A toggling, B stalled 3 cycles at beat 2
    launch(5'd4);
    run_stream(4, 1, 1, 0, cyc);
    finish_job(45'h1F_FFFF_0000, 1'b1, 1'b0);

    // start and write during SEND are dropped
    launch(5'd4);
    run_stream(4, 0, 0, 1, cyc);
    finish_job(45'h0_0000_0123, 1'b0, 1'b1);

    // single-element job
    launch(5'd1);
    run_stream(1, 0, 0, 0, cyc);
    finish_job(45'h0_4000_0000, 1'b0, 1'b0);

    bad_len(5'd0);
    bad_len(5'd17);

    // reset at beat 2, then a full relaunch
    launch(5'd4);
    tick();
    tick();
    chk("pre_rst_a_data", A_data, exp_a[2]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_a_valid", A_valid, 0);
    chk("mid_rst_b_valid", B_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_result", result, 0);
    launch(5'd4);
    run_stream(4, 0, 0, 0, cyc);
    chk("relaunch_cycle", cyc, 4);
    finish_job(45'h0_8000_0000, 1'b0, 1'b0);

`ifdef VEC_TIMEOUT_EN
    launch(5'd1);
    run_stream(1, 0, 0, 0, cyc);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_busy", busy, 1);
      chk("to_no_done", done, 0);
    end
    tick();
    chk("to_idle", busy, 0);
    chk("to_flag", timeout, 1);
    chk("to_done", done, 0);
    chk("to_ready", out_ready, 0);
    tick();
    chk("to_sticky", timeout, 1);
    launch(5'd1);
    chk("to_cleared", timeout, 0);
    run_stream(1, 0, 0, 0, cyc);
    finish_job(45'h0_0000_0001, 1'b0, 1'b0);
`else
    chk("timeout_tied", timeout, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
